// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - signed pre-add/multiply/post-add pipeline with dot-product counter
// Optional build macro MAC_SAT_EN: P saturates on overflow instead of wrapping.
module dsp_mac_pipe #(
  parameter int A_W     = 18,
  parameter int B_W     = 18,
  parameter int P_W     = 48,
  parameter int ACC_LEN = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               in_valid,
  input  logic [3:0]         op,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  input  logic [B_W-1:0]     D,
  input  logic [P_W-1:0]     C,
  input  logic               acc_clr,
  output logic [A_W+B_W:0]   M,
  output logic [P_W-1:0]     P,
  output logic               out_valid,
  output logic               out_last,
  output logic               ovf
);
  localparam int M_W   = A_W + B_W + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic [A_W-1:0]   r_a1;
  logic [B_W:0]     r_b1;
  logic [P_W-1:0]   r_c1, r_c2;
  logic [1:0]       r_post1, r_post2;
  logic             r_v1, r_v2, r_clr1, r_clr2;
  logic [M_W-1:0]   r_prod;
  logic [CNT_W-1:0] r_cnt;

  logic [B_W:0]     w_b_ext, w_d_ext, w_pre;
  logic [M_W-1:0]   w_mul_a, w_mul_b, w_prod;
  logic [P_W:0]     w_m_ext, w_base, w_sum;
  logic             w_acc, w_last, w_ovf;
  logic [CNT_W-1:0] w_eff_cnt, w_cnt_nxt;
  logic [P_W-1:0]   w_p_nxt;

  assign w_b_ext = {B[B_W-1], B};
  assign w_d_ext = {D[B_W-1], D};
  assign w_pre   = op[0] ? (op[1] ? w_d_ext - w_b_ext : w_d_ext + w_b_ext) : w_b_ext;

  // Low M_W bits of the product of sign-extended operands equal the exact signed product.
  assign w_mul_a = {{(B_W+1){r_a1[A_W-1]}}, r_a1};
  assign w_mul_b = {{A_W{r_b1[B_W]}}, r_b1};
  assign w_prod  = w_mul_a * w_mul_b;

  // A tagged acc_clr forces the sample to be treated as the first of a run.
  assign w_m_ext   = {{(P_W+1-M_W){r_prod[M_W-1]}}, r_prod};
  assign w_acc     = r_post2[0];
  assign w_eff_cnt = r_clr2 ? '0 : r_cnt;
  assign w_base    = !w_acc ? {r_c2[P_W-1], r_c2} :
                     (w_eff_cnt == '0) ? '0 : {P[P_W-1], P};
  assign w_sum     = r_post2[1] ? w_base - w_m_ext : w_base + w_m_ext;
  assign w_ovf     = w_sum[P_W] ^ w_sum[P_W-1];
  assign w_last    = w_acc && (w_eff_cnt == CNT_W'(ACC_LEN-1));
  assign w_cnt_nxt = !w_acc ? w_eff_cnt : (w_last ? '0 : w_eff_cnt + CNT_W'(1));

`ifdef MAC_SAT_EN
  localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};
  assign w_p_nxt = !w_ovf ? w_sum[P_W-1:0] : (w_sum[P_W] ? P_MIN : P_MAX);
`else
  assign w_p_nxt = w_sum[P_W-1:0];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a1      <= '0;
      r_b1      <= '0;
      r_c1      <= '0;
      r_c2      <= '0;
      r_post1   <= '0;
      r_post2   <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_clr1    <= 1'b0;
      r_clr2    <= 1'b0;
      r_prod    <= '0;
      r_cnt     <= '0;
      M         <= '0;
      P         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else if (CE) begin
      r_a1      <= A;
      r_b1      <= w_pre;
      r_c1      <= C;
      r_post1   <= op[3:2];
      r_v1      <= in_valid;
      r_clr1    <= acc_clr;
      r_prod    <= w_prod;
      r_c2      <= r_c1;
      r_post2   <= r_post1;
      r_v2      <= r_v1;
      r_clr2    <= r_clr1;
      out_valid <= r_v2;
      out_last  <= r_v2 & w_last;
      if (r_v2) begin
        M     <= r_prod;
        P     <= w_p_nxt;
        ovf   <= w_ovf;
        r_cnt <= w_cnt_nxt;
      end
    end
  end
endmodule
